// File: rtl/hsi_mse_streamer.sv
// Streams one held pixel vector paired word-by-word with N library vectors per start command.
// Reads issue one per cycle; each word appears on the element outputs two cycles after its read.
module hsi_mse_streamer #(
   parameter int WORD_WIDTH       = 32,
   parameter int DATA_WIDTH       = 16,
   parameter int HSI_BANDS        = 128,
   parameter int HSI_LIBRARY_SIZE = 16,
   localparam int ELEMENTS              = HSI_BANDS / (WORD_WIDTH / DATA_WIDTH),
   localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE),
   localparam int ELEMENTS_ADDR         = $clog2(ELEMENTS),
   localparam int LIB_ADDR              = $clog2(HSI_LIBRARY_SIZE * ELEMENTS)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             px_wr_en,
   input  logic [ELEMENTS_ADDR-1:0]         px_wr_addr,
   input  logic [WORD_WIDTH-1:0]            px_wr_data,
   input  logic                             start,
   input  logic [HSI_LIBRARY_SIZE_ADDR:0]   lib_size,
   output logic                             lib_rd_en,
   output logic [LIB_ADDR-1:0]              lib_rd_addr,
   input  logic [WORD_WIDTH-1:0]            lib_rd_data,
   output logic                             element_start,
   output logic                             element_last,
   output logic [WORD_WIDTH-1:0]            element_a,
   output logic [WORD_WIDTH-1:0]            element_b,
   output logic                             element_valid,
   output logic [HSI_LIBRARY_SIZE_ADDR-1:0] vctr_ref,
   output logic                             busy,
   output logic                             done
);

   localparam int SIZE_W = HSI_LIBRARY_SIZE_ADDR + 1;
   localparam logic [ELEMENTS_ADDR-1:0] WORD_LAST = ELEMENTS_ADDR'(ELEMENTS - 1);
   localparam logic [SIZE_W-1:0]        SIZE_MAX  = SIZE_W'(HSI_LIBRARY_SIZE);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                           state, state_nxt;
   logic [ELEMENTS_ADDR-1:0]         word_cnt;
   logic [HSI_LIBRARY_SIZE_ADDR-1:0] vec_cnt, vec_last;
   logic                             drain_cnt;
   logic [SIZE_W-1:0]                eff_size;
   logic                             read_end;
   logic [WORD_WIDTH-1:0]            px_mem [ELEMENTS];

   logic                             p1_vld;
   logic [ELEMENTS_ADDR-1:0]         p1_word;
   logic [HSI_LIBRARY_SIZE_ADDR-1:0] p1_vec;
   logic [WORD_WIDTH-1:0]            p1_pix;

   always_comb begin
      eff_size = (lib_size > SIZE_MAX) ? SIZE_MAX : lib_size;
      read_end = (word_cnt == WORD_LAST) && (vec_cnt == vec_last);
   end

   always_comb begin
      state_nxt = state;
      lib_rd_en = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = (eff_size == '0) ? DONE : READ;
         end
         READ: begin
            lib_rd_en = 1'b1;
            if (read_end) state_nxt = DRAIN;
         end
         DRAIN: if (drain_cnt) state_nxt = DONE;
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      lib_rd_addr = lib_rd_en ? LIB_ADDR'(int'(vec_cnt) * ELEMENTS + int'(word_cnt)) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         word_cnt  <= '0;
         vec_cnt   <= '0;
         vec_last  <= '0;
         drain_cnt <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (start) begin
               word_cnt  <= '0;
               vec_cnt   <= '0;
               vec_last  <= HSI_LIBRARY_SIZE_ADDR'(eff_size - SIZE_W'(1));
               drain_cnt <= 1'b0;
            end
            READ: begin
               if (word_cnt == WORD_LAST) begin
                  word_cnt <= '0;
                  vec_cnt  <= vec_cnt + HSI_LIBRARY_SIZE_ADDR'(1);
               end else begin
                  word_cnt <= word_cnt + ELEMENTS_ADDR'(1);
               end
            end
            DRAIN: drain_cnt <= ~drain_cnt;
            default: ;
         endcase
      end
   end

   // Pixel buffer is deliberately left out of reset so a sweep can be rerun after an abort.
   always_ff @(posedge clk) begin
      if (px_wr_en && state == IDLE) px_mem[px_wr_addr] <= px_wr_data;
   end

   // Stage 1 travels with the read; stage 2 meets the returning library word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p1_vld        <= 1'b0;
         p1_word       <= '0;
         p1_vec        <= '0;
         p1_pix        <= '0;
         element_valid <= 1'b0;
         element_start <= 1'b0;
         element_last  <= 1'b0;
         element_a     <= '0;
         element_b     <= '0;
         vctr_ref      <= '0;
      end else begin
         p1_vld        <= lib_rd_en;
         p1_word       <= word_cnt;
         p1_vec        <= vec_cnt;
         p1_pix        <= px_mem[word_cnt];
         element_valid <= p1_vld;
         element_start <= p1_vld && (p1_word == '0);
         element_last  <= p1_vld && (p1_word == WORD_LAST);
         element_a     <= p1_vld ? p1_pix : '0;
         element_b     <= p1_vld ? lib_rd_data : '0;
         vctr_ref      <= p1_vld ? p1_vec : '0;
      end
   end

endmodule
